// File: rtl/div_seq.sv
// Iterative RV32M divider sequencer: restoring division through an external shared adder, one quotient bit per cycle.
// Latency: 1 + WIDTH + [neg a] + [neg b] + [fix] cycles from accept to resp_valid; divide-by-zero and overflow take 1 cycle.
// Backpressure: holds the result in DONE until resp_ready; req_ready is low whenever not IDLE.
package div_seq_pkg;
    typedef enum logic [1:0] {
        ADDER_ADD = 2'd0,
        ADDER_SUB = 2'd1
    } adderOp_t;
endpackage

module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output adderOp_t         add_op,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic             op_rem;
    logic             sq;
    logic             sr;
    logic             neg_b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] p;
    logic             take;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic             need_fix;

    // Unsigned ops treat both operands as non-negative.
    assign a_neg    = ~req_op[0] & req_a[WIDTH-1];
    assign b_neg    = ~req_op[0] & req_b[WIDTH-1];
    assign div_zero = (req_b == '0);
    assign ovf      = ~req_op[0] & (req_a == INT_MIN) & (&req_b);

    // A set rem msb means the shifted partial remainder already exceeds any divisor.
    assign p        = {rem[WIDTH-2:0], q[WIDTH-1]};
    assign take     = rem[WIDTH-1] | ~add_cout;
    assign q_nxt    = {q[WIDTH-2:0], take};
    assign rem_nxt  = take ? add_out : p;
    assign need_fix = op_rem ? sr : sq;

    always_comb begin
        add_op = ADDER_ADD;
        add_a  = '0;
        add_b  = '0;
        case (state)
            S_NEG_A: begin
                add_op = ADDER_SUB;
                add_b  = q;
            end
            S_NEG_B: begin
                add_op = ADDER_SUB;
                add_b  = dvs;
            end
            S_ITER: begin
                add_op = ADDER_SUB;
                add_a  = p;
                add_b  = dvs;
            end
            S_FIX: begin
                add_op = ADDER_SUB;
                add_b  = op_rem ? rem : q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
            op_rem     <= 1'b0;
            sq         <= 1'b0;
            sr         <= 1'b0;
            neg_b      <= 1'b0;
            q          <= '0;
            rem        <= '0;
            dvs        <= '0;
            cnt        <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_rem    <= req_op[1];
                        sq        <= a_neg ^ b_neg;
                        sr        <= a_neg;
                        neg_b     <= b_neg;
                        q         <= req_a;
                        dvs       <= req_b;
                        rem       <= '0;
                        cnt       <= CW'(WIDTH - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (div_zero) begin
                            resp_data  <= req_op[1] ? req_a : '1;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end else if (ovf) begin
                            resp_data  <= req_op[1] ? '0 : INT_MIN;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end else if (a_neg) begin
                            state <= S_NEG_A;
                        end else if (b_neg) begin
                            state <= S_NEG_B;
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                S_NEG_A: begin
                    q     <= add_out;
                    state <= neg_b ? S_NEG_B : S_ITER;
                end
                S_NEG_B: begin
                    dvs   <= add_out;
                    state <= S_ITER;
                end
                S_ITER: begin
                    q   <= q_nxt;
                    rem <= rem_nxt;
                    if (cnt == '0) begin
                        if (need_fix) begin
                            state <= S_FIX;
                        end else begin
                            resp_data  <= op_rem ? rem_nxt : q_nxt;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    resp_data  <= add_out;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
